// File: rtl/pixel_packetizer.sv
// pixel_packetizer: tags RGB444 capture pixels with sop/eop frame markers
// and buffers them in a small FIFO toward a ready/valid downstream filter.
//   clk, reset (async active-low)
//   pix_data/pix_valid/frame_start : capture side, no backpressure
//   data_out/sop_out/eop_out/valid_out/ready_in : downstream beat handshake
//   overflow    : sticky, a pixel of the current frame was dropped (FIFO full)
//   frame_error : sticky, a frame restarted before reaching its eop
module pixel_packetizer #(
    parameter int FRAME_W    = 320,
    parameter int FRAME_H    = 240,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] pix_data,
    input  logic        pix_valid,
    input  logic        frame_start,
    input  logic        ready_in,
    output logic [11:0] data_out,
    output logic        sop_out,
    output logic        eop_out,
    output logic        valid_out,
    output logic        overflow,
    output logic        frame_error
);
    localparam int NPIX = FRAME_W * FRAME_H;
    localparam int CW = NPIX > 1 ? $clog2(NPIX) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(NPIX - 1);
    localparam logic [AW:0] FULL_OCC = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     occ_q;
    logic            ovf_q, ferr_q;
    logic [13:0]     mem_q [FIFO_DEPTH];

    logic            accept, last, full, push, pop;
    logic [CW-1:0]   idx;
    logic [13:0]     head;

    // A frame_start always restarts numbering at 0, whatever the state.
    assign accept = pix_valid && (frame_start || state_q == ACTIVE);
    assign idx    = frame_start ? '0 : cnt_q;
    assign last   = idx == LAST;
    // Full is judged on the pre-pop occupancy, so a full FIFO drops even if
    // the downstream is draining a beat in the same cycle.
    assign full   = occ_q == FULL_OCC;
    assign push   = accept && !full;
    assign pop    = valid_out && ready_in;

    assign valid_out = occ_q != '0;
    assign head      = mem_q[rd_q];
    assign {sop_out, eop_out, data_out} = valid_out ? head : 14'd0;
    assign overflow    = ovf_q;
    assign frame_error = ferr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            occ_q   <= '0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            // The counter advances even on a dropped pixel so eop stays put.
            if (accept) begin
                cnt_q   <= last ? '0 : idx + 1'b1;
                state_q <= last ? IDLE : ACTIVE;
                ovf_q   <= (ovf_q && !frame_start) || full;
            end
            if (pix_valid && frame_start && state_q == ACTIVE)
                ferr_q <= 1'b1;
            if (push)
                wr_q <= wr_q + 1'b1;
            if (pop)
                rd_q <= rd_q + 1'b1;
            occ_q <= occ_q + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q] <= {frame_start, last, pix_data};
    end
endmodule

// File: doc/pixel_packetizer.md
PIXEL_PACKETIZER -- requirements
Module: pixel_packetizer

Interface
REQ-001 SHALL have parameter FRAME_W, default 320: active pixels per line.
REQ-002 SHALL have parameter FRAME_H, default 240: active lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, power of two, at least 2: output buffer entries.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
REQ-006 SHALL have port pix_data  input  12  raw RGB444 capture pixel {R[11:8], G[7:4], B[3:0]}.
REQ-007 SHALL have port pix_valid  input  1  pix_data is valid this cycle; no backpressure toward capture.
REQ-008 SHALL have port frame_start  input  1  qualified by pix_valid; marks the first pixel of a frame.
REQ-009 SHALL have port ready_in  input  1  downstream filter accepts the output beat this cycle.
REQ-010 SHALL have port data_out  output  12  pixel presented downstream.
REQ-011 SHALL have port sop_out  output  1  data_out is pixel 0 of the frame.
REQ-012 SHALL have port eop_out  output  1  data_out is pixel FRAME_W*FRAME_H-1.
REQ-013 SHALL have port valid_out  output  1  data_out, sop_out and eop_out are valid.
REQ-014 SHALL have port overflow  output  1  sticky flag: a pixel was dropped in the current frame.
REQ-015 SHALL have port frame_error  output  1  sticky flag: a frame was restarted before its eop.

Function
REQ-016 SHALL implement FSM states IDLE and ACTIVE; pixel counter width SHALL be ceil(log2(FRAME_W*FRAME_H)) bits.
REQ-017 IDLE: pix_valid without frame_start ignored (not counted, not buffered).
REQ-018 IDLE with pix_valid and frame_start: pixel is index 0, tagged sop; counter goes to 1; state goes to ACTIVE; overflow cleared.
REQ-019 ACTIVE with pix_valid and no frame_start: pixel tagged with current counter index; counter increments.
REQ-020 The pixel at index FRAME_W*FRAME_H-1 SHALL be tagged eop; counter returns to 0 and state returns to IDLE in the same cycle.
REQ-021 When FRAME_W*FRAME_H equals 1, pixel 0 SHALL carry both sop and eop.
REQ-022 ACTIVE with pix_valid and frame_start: frame_error set; the pixel is treated as index 0 of a new frame (sop, counter to 1, overflow cleared); the previous packet is left without eop.
REQ-023 Each tagged pixel SHALL be written as {sop, eop, data} into a FIFO_DEPTH-entry FIFO.
REQ-024 FIFO full SHALL be evaluated before any same-cycle pop.
REQ-025 A pixel arriving while the FIFO is full SHALL be dropped and set overflow; the counter still advances, so frame geometry and the eop position are preserved.
REQ-026 A dropped sop or eop beat SHALL NOT be re-tagged onto a later pixel.
REQ-027 valid_out SHALL equal FIFO not-empty; data_out, sop_out and eop_out SHALL be the FIFO head.
REQ-028 A beat SHALL be popped when valid_out and ready_in are both 1.
REQ-029 While valid_out is 1 and ready_in is 0, the head beat SHALL hold stable.
REQ-030 Latency SHALL be one cycle: a pixel written at edge N into an empty FIFO shows valid_out=1 after edge N.
REQ-031 Simultaneous push and pop on a non-full FIFO SHALL leave occupancy unchanged and preserve order.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH; a separate occupancy count distinguishes full from empty.
REQ-033 frame_error SHALL clear only on reset; overflow SHALL clear on reset or on an accepted frame_start.

Reset
REQ-034 On reset=0, asynchronously: state IDLE, counter 0, FIFO empty, and valid_out, sop_out, eop_out, overflow, frame_error all 0.
REQ-035 On reset=0, data_out SHALL be 0.
REQ-036 Reset asserted mid-frame SHALL discard all buffered beats; after release the block waits in IDLE for frame_start.

Verification
REQ-037 Bench SHALL run FRAME_W=4, FRAME_H=2, FIFO_DEPTH=4, ready_in=1, and feed 8 pixels 0x001..0x008 with frame_start on the first -> 8 output beats, sop on 0x001 only, eop on 0x008 only, each one cycle after input.
REQ-038 Bench SHALL feed 3 pixels before any frame_start, then a valid frame -> the 3 pixels are absent and the output starts at the sop pixel.
REQ-039 Bench SHALL hold ready_in=0 and feed 6 pixels of a frame -> first 4 buffered, pixels 5-6 dropped, overflow=1; release ready_in -> 4 beats out in order; remaining frame pixels give eop on index 7.
REQ-040 Bench SHALL assert frame_start at index 3 of a frame -> frame_error=1, new sop beat emitted, no eop on the aborted packet, next eop at index 7 of the new frame.
REQ-041 Bench SHALL toggle ready_in every cycle during a full frame -> no beat lost or duplicated, head stable while ready_in=0.
REQ-042 Bench SHALL assert reset=0 with 3 beats buffered -> valid_out falls immediately and all flags are 0; after release, stray pixels are ignored until frame_start.
